// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizing constants, data types and FSM encoding for the
//            general-purpose register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REGS = 64;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    // Address of the last register covered by the zero sweep
    localparam reg_addr_t c_LAST_ADDR = reg_addr_t'(NUM_REGS - 1);

    // True when the address maps onto real storage; out-of-range addresses
    // read as zero and swallow writes.
    function automatic logic addr_in_range(input reg_addr_t addr);
        return (32'(addr) < 32'(NUM_REGS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_init_seq
// Purpose  : INIT/RUN sequencer for the register file. After reset it walks
//            every register address once, requesting a zero write per cycle,
//            then raises ready and stays in RUN until the next reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_init_seq
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    rf_state_t r_state;
    rf_state_t w_state_nxt;
    reg_addr_t r_init_cnt;
    reg_addr_t w_init_cnt_nxt;
    logic      r_ready;
    logic      w_ready_nxt;

    // State, sweep counter and ready flag; reset restarts the sweep
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RF_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    // Next state: one zero write per INIT cycle, leave after the last address
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_ready_nxt    = r_ready;
        init_we        = 1'b0;
        init_addr      = r_init_cnt;

        if (r_state == RF_INIT) begin
            init_we        = 1'b1;
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            if (r_init_cnt == c_LAST_ADDR) begin
                w_state_nxt = RF_RUN;
                w_ready_nxt = 1'b1;
            end
        end
    end

    assign ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 3-read / 2-write general-purpose register file with registered
//            read data, zero-fill sweep after reset and a ready flag.
//            Optional build macro REGFILE_BYPASS_EN: when defined, a read of
//            an address written in the same cycle returns the new data
//            (port 2 first); otherwise the read returns the old value.
// Revision : 1.0 - initial release
// ============================================================================
module register_file
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] reg_rd1,
    input  logic [ADDR_W-1:0] reg_rd2,
    input  logic [ADDR_W-1:0] reg_rd3,
    output logic [DATA_W-1:0] reg_rd1_out,
    output logic [DATA_W-1:0] reg_rd2_out,
    output logic [DATA_W-1:0] reg_rd3_out,
    input  logic [ADDR_W-1:0] reg_wr1,
    input  logic [DATA_W-1:0] reg_wr1_data,
    input  logic              reg_wr1_enable,
    input  logic [ADDR_W-1:0] reg_wr2,
    input  logic [DATA_W-1:0] reg_wr2_data,
    input  logic              reg_wr2_enable,
    output logic              ready
);

    localparam int c_NUM_RD = 3;

    reg_data_t r_mem     [NUM_REGS];
    reg_data_t r_rd_out  [c_NUM_RD];
    reg_data_t w_rd_val  [c_NUM_RD];
    reg_addr_t w_rd_addr [c_NUM_RD];

    logic      w_init_we;
    reg_addr_t w_init_addr;
    logic      w_wr1_go;
    logic      w_wr2_go;

    regfile_init_seq u_init_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .ready     (ready)
    );

    // User writes only take effect in RUN and only to real registers
    assign w_wr1_go = !w_init_we && reg_wr1_enable && addr_in_range(reg_wr1);
    assign w_wr2_go = !w_init_we && reg_wr2_enable && addr_in_range(reg_wr2);

    assign w_rd_addr[0] = reg_rd1;
    assign w_rd_addr[1] = reg_rd2;
    assign w_rd_addr[2] = reg_rd3;

    // Storage update: the zero sweep owns the array during INIT; in RUN port 2
    // is assigned last so it overrides port 1 on an address collision
    always_ff @(posedge clock) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= '0;
        end else begin
            if (w_wr1_go) begin
                r_mem[reg_wr1] <= reg_wr1_data;
            end
            if (w_wr2_go) begin
                r_mem[reg_wr2] <= reg_wr2_data;
            end
        end
    end

    // Read data selection per port, with optional same-cycle write forwarding
    always_comb begin
        for (int p = 0; p < c_NUM_RD; p++) begin
            w_rd_val[p] = '0;
            if (addr_in_range(w_rd_addr[p])) begin
                w_rd_val[p] = r_mem[w_rd_addr[p]];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr1_go && (reg_wr1 == w_rd_addr[p])) begin
                w_rd_val[p] = reg_wr1_data;
            end
            if (w_wr2_go && (reg_wr2 == w_rd_addr[p])) begin
                w_rd_val[p] = reg_wr2_data;
            end
`endif
        end
    end

    // Read output registers: forced to zero until the sweep has finished
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < c_NUM_RD; p++) begin
                r_rd_out[p] <= '0;
            end
        end else begin
            for (int p = 0; p < c_NUM_RD; p++) begin
                r_rd_out[p] <= w_init_we ? '0 : w_rd_val[p];
            end
        end
    end

    assign reg_rd1_out = r_rd_out[0];
    assign reg_rd2_out = r_rd_out[1];
    assign reg_rd3_out = r_rd_out[2];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file: directed scenarios plus
//            randomized traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int c_REGS = 64;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  reg_rd1, reg_rd2, reg_rd3;
    logic [15:0] reg_rd1_out, reg_rd2_out, reg_rd3_out;
    logic [5:0]  reg_wr1, reg_wr2;
    logic [15:0] reg_wr1_data, reg_wr2_data;
    logic        reg_wr1_enable, reg_wr2_enable;
    logic        ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [c_REGS];
    bit          m_ready;
    int          m_cnt;
    logic [15:0] exp_rd [3];

    register_file dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .reg_rd1        (reg_rd1),
        .reg_rd2        (reg_rd2),
        .reg_rd3        (reg_rd3),
        .reg_rd1_out    (reg_rd1_out),
        .reg_rd2_out    (reg_rd2_out),
        .reg_rd3_out    (reg_rd3_out),
        .reg_wr1        (reg_wr1),
        .reg_wr1_data   (reg_wr1_data),
        .reg_wr1_enable (reg_wr1_enable),
        .reg_wr2        (reg_wr2),
        .reg_wr2_data   (reg_wr2_data),
        .reg_wr2_enable (reg_wr2_enable),
        .ready          (ready)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        reg_wr1_enable = 1'b0;
        reg_wr2_enable = 1'b0;
        reg_wr1 = '0; reg_wr2 = '0;
        reg_wr1_data = '0; reg_wr2_data = '0;
        reg_rd1 = '0; reg_rd2 = '0; reg_rd3 = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_REGS; i++) m_mem[i] = 16'h0000;
        m_ready = 1'b0;
        m_cnt   = 0;
        for (int p = 0; p < 3; p++) exp_rd[p] = 16'h0000;
    endtask

    // Advance one clock: predict read results from the model using the inputs
    // currently applied, update the model, then move to 1 time unit past the edge.
    task automatic tick();
        logic [5:0] a [3];
        a[0] = reg_rd1; a[1] = reg_rd2; a[2] = reg_rd3;
        if (m_ready) begin
            for (int p = 0; p < 3; p++) begin
                exp_rd[p] = m_mem[a[p]];
`ifdef REGFILE_BYPASS_EN
                if (reg_wr1_enable && reg_wr1 == a[p]) exp_rd[p] = reg_wr1_data;
                if (reg_wr2_enable && reg_wr2 == a[p]) exp_rd[p] = reg_wr2_data;
`endif
            end
            if (reg_wr1_enable) m_mem[reg_wr1] = reg_wr1_data;
            if (reg_wr2_enable) m_mem[reg_wr2] = reg_wr2_data;
        end else begin
            for (int p = 0; p < 3; p++) exp_rd[p] = 16'h0000;
            m_cnt++;
            if (m_cnt == c_REGS) m_ready = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [5:0] addr, input logic [15:0] data);
        reg_wr1 = addr; reg_wr1_data = data; reg_wr1_enable = 1'b1;
        tick();
        reg_wr1_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", ready);
        end
        checks++;
        if ({reg_rd1_out, reg_rd2_out, reg_rd3_out} !== 48'h0) begin
            errors++; $display("FAIL reset_outs got %h %h %h exp 0", reg_rd1_out, reg_rd2_out, reg_rd3_out);
        end
        reset_n = 1'b1;
        // A write attempted during the sweep must be ignored
        reg_rd1 = 6'd5;
        reg_wr1 = 6'd1; reg_wr1_data = 16'hFFFF; reg_wr1_enable = 1'b1;
        for (int k = 1; k <= c_REGS; k++) begin
            tick();
            checks++;
            if (ready !== (k == c_REGS)) begin
                errors++; $display("FAIL init_ready cycle %0d got %b exp %b", k, ready, (k == c_REGS));
            end
            checks++;
            if (reg_rd1_out !== 16'h0000) begin
                errors++; $display("FAIL init_rd1 cycle %0d got %h exp 0000", k, reg_rd1_out);
            end
        end
        reg_wr1_enable = 1'b0;
        tick();
        checks++;
        if (reg_rd1_out !== 16'h0000) begin
            errors++; $display("FAIL read_r5_after_init got %h exp 0000", reg_rd1_out);
        end
        reg_rd1 = 6'd1;
        tick();
        checks++;
        if (reg_rd1_out !== 16'h0000) begin
            errors++; $display("FAIL init_write_dropped got %h exp 0000", reg_rd1_out);
        end
    endtask

    task automatic test_write_read();
        write_reg(6'd3, 16'h1234);
        reg_rd1 = 6'd3;
        tick();
        checks++;
        if (reg_rd1_out !== 16'h1234) begin
            errors++; $display("FAIL write_read_r3 got %h exp 1234", reg_rd1_out);
        end
    endtask

    task automatic test_write_collision();
        reg_wr1 = 6'd7; reg_wr1_data = 16'hAAAA; reg_wr1_enable = 1'b1;
        reg_wr2 = 6'd7; reg_wr2_data = 16'hBEEF; reg_wr2_enable = 1'b1;
        tick();
        reg_wr1_enable = 1'b0; reg_wr2_enable = 1'b0;
        reg_rd3 = 6'd7;
        tick();
        checks++;
        if (reg_rd3_out !== 16'hBEEF) begin
            errors++; $display("FAIL collision_r7 got %h exp BEEF", reg_rd3_out);
        end
    endtask

    task automatic test_read_during_write();
        logic [15:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 16'h1111;
`else
        want = 16'h0000;
`endif
        write_reg(6'd9, 16'h0000);
        reg_wr1 = 6'd9; reg_wr1_data = 16'h1111; reg_wr1_enable = 1'b1;
        reg_rd2 = 6'd9;
        tick();
        reg_wr1_enable = 1'b0;
        checks++;
        if (reg_rd2_out !== want) begin
            errors++; $display("FAIL rdw_same_cycle got %h exp %h", reg_rd2_out, want);
        end
        tick();
        checks++;
        if (reg_rd2_out !== 16'h1111) begin
            errors++; $display("FAIL rdw_next_cycle got %h exp 1111", reg_rd2_out);
        end
    endtask

    task automatic test_multi_read();
        reg_wr1 = 6'd1; reg_wr1_data = 16'h0001; reg_wr1_enable = 1'b1;
        reg_wr2 = 6'd2; reg_wr2_data = 16'h0002; reg_wr2_enable = 1'b1;
        tick();
        reg_wr2_enable = 1'b0;
        reg_wr1 = 6'd3; reg_wr1_data = 16'h0003;
        tick();
        reg_wr1_enable = 1'b0;
        reg_rd1 = 6'd1; reg_rd2 = 6'd2; reg_rd3 = 6'd3;
        tick();
        checks++;
        if ({reg_rd1_out, reg_rd2_out, reg_rd3_out} !== {16'h0001, 16'h0002, 16'h0003}) begin
            errors++; $display("FAIL multi_read_123 got %h %h %h exp 0001 0002 0003", reg_rd1_out, reg_rd2_out, reg_rd3_out);
        end
        reg_rd1 = 6'd3; reg_rd2 = 6'd3; reg_rd3 = 6'd3;
        tick();
        checks++;
        if ({reg_rd1_out, reg_rd2_out, reg_rd3_out} !== {16'h0003, 16'h0003, 16'h0003}) begin
            errors++; $display("FAIL multi_read_333 got %h %h %h exp 0003 0003 0003", reg_rd1_out, reg_rd2_out, reg_rd3_out);
        end
    endtask

    task automatic test_reset_midrun();
        write_reg(6'd3, 16'h5555);
        reg_rd1 = 6'd3;
        tick();
        checks++;
        if (reg_rd1_out !== 16'h5555) begin
            errors++; $display("FAIL midrun_pre got %h exp 5555", reg_rd1_out);
        end
        // Reset lands mid-cycle while a write is being presented
        reg_wr1 = 6'd3; reg_wr1_data = 16'h7777; reg_wr1_enable = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL midrun_ready got %b exp 0", ready);
        end
        checks++;
        if (reg_rd1_out !== 16'h0000) begin
            errors++; $display("FAIL midrun_outs got %h exp 0000", reg_rd1_out);
        end
        reg_wr1_enable = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= c_REGS; k++) tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL midrun_reinit_ready got %b exp 1", ready);
        end
        tick();
        checks++;
        if (reg_rd1_out !== 16'h0000) begin
            errors++; $display("FAIL midrun_r3_cleared got %h exp 0000", reg_rd1_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            reg_wr1 = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            reg_wr2 = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            reg_rd1 = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            reg_rd2 = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            reg_rd3 = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom);
            reg_wr1_data = 16'($urandom);
            reg_wr2_data = 16'($urandom);
            reg_wr1_enable = ($urandom_range(0, 2) != 0);
            reg_wr2_enable = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if ({reg_rd1_out, reg_rd2_out, reg_rd3_out} !== {exp_rd[0], exp_rd[1], exp_rd[2]}) begin
                errors++;
                $display("FAIL random_read iter %0d got %h %h %h exp %h %h %h", n,
                         reg_rd1_out, reg_rd2_out, reg_rd3_out, exp_rd[0], exp_rd[1], exp_rd[2]);
            end
            checks++;
            if (ready !== 1'b1) begin
                errors++; $display("FAIL random_ready iter %0d got %b exp 1", n, ready);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_collision();
        test_read_during_write();
        test_multi_read();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
